// File: rtl/serial_addsub_pkg.sv
// ============================================================================
// Module      : serial_addsub_pkg
// Description : Shared types and helpers for the bit-serial add/subtract unit.
//               Holds the FSM state encoding, the step-count helper and the
//               step-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

    // Two-bit state encoding; the unused code 2'b11 falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN steps needed to sweep an operand of the given width.
    function automatic int calc_steps(input int width, input int digit);
        return width / digit;
    endfunction

    // Step counter width: enough to index every step, never narrower than 1.
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage : serial_addsub_pkg

`default_nettype wire

// File: rtl/serial_addsub_if.sv
// ============================================================================
// Module      : serial_addsub_if
// Description : Request/result bundle of the bit-serial add/subtract unit.
//   start      : request, sampled only while the unit is idle
//   sub        : 0 = a+b, 1 = a-b
//   a, b       : WIDTH-bit signed operands
//   busy       : unit is running or presenting its result
//   done       : one-cycle pulse, result valid
//   sum        : WIDTH+1-bit signed exact result
//   carry_out  : unsigned carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//   overflow   : WIDTH-bit signed overflow
// Modports    : master (requester), slave (the unit)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_addsub_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry_out, overflow
    );
endinterface : serial_addsub_if

`default_nettype wire

// File: rtl/serial_addsub_digit_adder.sv
// ============================================================================
// Module      : digit_adder
// Description : DIGIT-bit combinational ripple-carry adder slice.
//   a, b      : DIGIT-bit addends
//   ci        : carry in
//   s         : DIGIT-bit sum
//   co        : carry out of the top bit
//   c_msb_in  : carry into the top bit (pairs with co for signed overflow)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_adder #(
    parameter int DIGIT = 1
) (
    input  wire logic [DIGIT-1:0] a,
    input  wire logic [DIGIT-1:0] b,
    input  wire logic             ci,
    output logic      [DIGIT-1:0] s,
    output logic                  co,
    output logic                  c_msb_in
);

    // c[i] is the carry into bit i; c[DIGIT] leaves the slice.
    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co       = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule : digit_adder

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial signed add/subtract. Operands are captured on an
//               accepted start, then DIGIT bits per cycle are pushed through
//               one shared ripple slice. Produces an exact WIDTH+1-bit result
//               plus unsigned carry and WIDTH-bit signed overflow flags.
//   clock     : rising-edge clock
//   reset     : asynchronous, active-high reset
//   bus       : serial_addsub_if slave (start/sub/a/b in, busy/done/sum/
//               carry_out/overflow out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  wire logic          clock,
    input  wire logic          reset,
    serial_addsub_if.slave     bus
);

    localparam int N     = calc_steps(WIDTH, DIGIT);
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_addsub: WIDTH must be at least 2");
    end
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("serial_addsub: DIGIT must divide WIDTH");
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;        // holds ~b for subtraction
    logic               carry_q,     carry_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH:0]     sum_q,       sum_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q,  overflow_d;

    logic [DIGIT-1:0]   dig_a;
    logic [DIGIT-1:0]   dig_b;
    logic [DIGIT-1:0]   dig_s;
    logic               dig_co;
    logic               dig_c_msb_in;
    logic               last_step;

    assign dig_a     = a_q[cnt_q*DIGIT +: DIGIT];
    assign dig_b     = b_q[cnt_q*DIGIT +: DIGIT];
    assign last_step = (cnt_q == LAST_STEP);

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a        (dig_a),
        .b        (dig_b),
        .ci       (carry_q),
        .s        (dig_s),
        .co       (dig_co),
        .c_msb_in (dig_c_msb_in)
    );

    // ------------------------------------------------------------------
    // Process 1: state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: datapath updates and outputs
    // ------------------------------------------------------------------
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1; the +1 enters as carry-in.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                sum_d[cnt_q*DIGIT +: DIGIT] = dig_s;
                carry_d = dig_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_step) begin
                    // Sign of the exact result: operand sign bits extended
                    // one place and added with the final carry.
                    sum_d[WIDTH] = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ dig_co;
                    carry_out_d  = dig_co;
                    overflow_d   = dig_c_msb_in ^ dig_co;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.done      = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;

endmodule : serial_addsub

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub. Five configurations
//               share one stimulus stream; each has a cycle-level behavioural
//               model computing a +/- b with plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub;

    localparam int NDUT = 5;
    localparam int WS [NDUT] = '{32, 32, 32, 8, 8};
    localparam int DS [NDUT] = '{ 1,  4, 32, 1, 8};

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;

    logic [NDUT-1:0] done_v;
    logic [NDUT-1:0] busy_v;
    logic [NDUT-1:0] co_v;
    logic [NDUT-1:0] ov_v;
    logic [32:0]     sum_v [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // DUT instances with per-instance reference model
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = WS[g];
        localparam int D = DS[g];
        localparam int N = W / D;

        serial_addsub_if #(.WIDTH(W)) bus ();

        assign bus.start = start;
        assign bus.sub   = sub;
        assign bus.a     = a[W-1:0];
        assign bus.b     = b[W-1:0];

        serial_addsub #(.WIDTH(W), .DIGIT(D)) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        assign done_v[g] = bus.done;
        assign busy_v[g] = bus.busy;
        assign co_v[g]   = bus.carry_out;
        assign ov_v[g]   = bus.overflow;
        assign sum_v[g]  = 33'(bus.sum);

        // Returns {carry, overflow, sum[W:0]} of x +/- y.
        function automatic logic [W+2:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic s);
            longint sx, sy, ux, uy, ex, lim;
            logic [63:0] ev;
            logic co, ov;
            sx  = longint'($signed(x));
            sy  = longint'($signed(y));
            ux  = longint'(x);
            uy  = longint'(y);
            ex  = s ? (sx - sy) : (sx + sy);
            lim = longint'(1) << (W - 1);
            ov  = (ex >= lim) || (ex < -lim);
            co  = s ? (ux >= uy) : ((ux + uy) >= (longint'(1) << W));
            ev  = ex;
            return {co, ov, ev[W:0]};
        endfunction

        bit           m_busy;
        int           m_cyc;
        logic [W+2:0] m_pend;
        logic [W:0]   e_sum;
        logic         e_co;
        logic         e_ov;

        always @(posedge clock or posedge reset) begin
            if (reset) begin
                m_busy <= 1'b0;
                m_cyc  <= 0;
                e_sum  <= '0;
                e_co   <= 1'b0;
                e_ov   <= 1'b0;
            end else if (m_busy) begin
                m_cyc <= m_cyc + 1;
                if (m_cyc == N - 1) begin
                    e_sum <= m_pend[W:0];
                    e_ov  <= m_pend[W+1];
                    e_co  <= m_pend[W+2];
                end
                if (m_cyc == N) m_busy <= 1'b0;
            end else if (start) begin
                m_busy <= 1'b1;
                m_cyc  <= 0;
                m_pend <= ref_op(a[W-1:0], b[W-1:0], sub);
            end
        end

        always @(negedge clock) begin
            check($sformatf("w%0d_d%0d busy", W, D), 64'(bus.busy), 64'(m_busy));
            check($sformatf("w%0d_d%0d done", W, D), 64'(bus.done), 64'(m_busy && (m_cyc == N)));
            check($sformatf("w%0d_d%0d carry_out", W, D), 64'(bus.carry_out), 64'(e_co));
            check($sformatf("w%0d_d%0d overflow", W, D), 64'(bus.overflow), 64'(e_ov));
            // Partial sums are legitimately visible while running.
            if (!(m_busy && (m_cyc < N)))
                check($sformatf("w%0d_d%0d sum", W, D), 64'(bus.sum), 64'(e_sum));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_idle();
        int n = 0;
        while ((busy_v != '0) && (n < 200)) begin
            @(posedge clock);
            n++;
        end
        check("idle_timeout", 64'(busy_v != '0), 64'(0));
    endtask

    // Accept happens on the posedge following the call; returns just after it.
    task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input logic xs);
        @(posedge clock);
        #1;
        a = xa; b = xb; sub = xs; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom);
    endtask

    task automatic wait_done(input int idx, input int exp_lat);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && (n < 100)) begin
            @(negedge clock);
            n++;
            seen = done_v[idx];
        end
        check($sformatf("dut%0d done_seen", idx), 64'(seen), 64'(1));
        check($sformatf("dut%0d latency", idx), 64'(n), 64'(exp_lat));
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0: v = 32'h0000_0000;
            1: v = 32'h0000_0001;
            2: v = 32'h7FFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'hFFFF_FFFF;
            5: v = 32'h0000_007F;
            6: v = 32'h0000_0080;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset busy", 64'(busy_v), 64'(0));
        check("reset sum0", 64'(sum_v[0]), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;

        // 32/1: 0x7FFFFFFF + 1 -> +2^31, overflow, no carry
        wait_idle();
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done(0, 33);
        check("d0 add sum", 64'(sum_v[0]), 64'(33'h0_8000_0000));
        check("d0 add ov",  64'(ov_v[0]), 64'(1));
        check("d0 add co",  64'(co_v[0]), 64'(0));

        // 32/4: 0 - 1 -> -1, borrow, no overflow
        wait_idle();
        do_op(32'h0000_0000, 32'h0000_0001, 1'b1);
        wait_done(1, 9);
        check("d1 sub sum", 64'(sum_v[1]), 64'(33'h1_FFFF_FFFF));
        check("d1 sub co",  64'(co_v[1]), 64'(0));
        check("d1 sub ov",  64'(ov_v[1]), 64'(0));

        // 32/32: 0x80000000 + 0x80000000 -> -2^32, overflow, carry
        wait_idle();
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done(2, 2);
        check("d2 add sum", 64'(sum_v[2]), 64'(33'h1_0000_0000));
        check("d2 add ov",  64'(ov_v[2]), 64'(1));
        check("d2 add co",  64'(co_v[2]), 64'(1));

        // Reset at step N/2 of the 32/1 unit
        wait_idle();
        do_op(32'h1234_5678, 32'h0000_1111, 1'b0);
        repeat (15) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst busy", 64'(busy_v), 64'(0));
        check("rst done", 64'(done_v), 64'(0));
        check("rst sum0", 64'(sum_v[0]), 64'(0));
        check("rst co",   64'(co_v), 64'(0));
        check("rst ov",   64'(ov_v), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        do_op(32'h0000_0005, 32'hFFFF_FFFD, 1'b0);
        wait_done(0, 33);
        check("post-rst sum", 64'(sum_v[0]), 64'(33'h0_0000_0002));
        check("post-rst ov",  64'(ov_v[0]), 64'(0));
        check("post-rst co",  64'(co_v[0]), 64'(1));

        // Start held high with operands changing every cycle
        wait_idle();
        @(posedge clock);
        #1;
        start = 1'b1;
        repeat (300) begin
            @(posedge clock);
            #1;
            a = rand_operand(); b = rand_operand(); sub = 1'($urandom);
        end
        start = 1'b0;

        // Randomised traffic with random start gaps
        wait_idle();
        repeat (15000) begin
            @(posedge clock);
            #1;
            start = 1'($urandom);
            a     = rand_operand();
            b     = rand_operand();
            sub   = 1'($urandom);
        end
        start = 1'b0;
        wait_idle();
        repeat (2) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_addsub

`default_nettype wire
